sort_stream_out: RTL and testbench
==================================

Name: sort_stream_out

Overview:
Downstream stage of the 8-entry byte bubble sorter. Captures the sorter's parallel result array (D0..D7) on the rising edge of its complete flag, then streams the entries out one per beat, index 0 first, over a valid/ready handshake. Tags the last beat, pulses done after it, and flags any out-of-order pair as an on-line check of the sorter.

Parameters:
N, 8, number of array entries (power of 2, ≥2)
W, 8, entry width in bits
IW, 3, index width, equal to log2(N)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
complete  input  1  sorter completion flag; level, stays high once sorting finishes
d_flat  input  N*W  sorter array; entry k at bits [k*W +: W] (D0 in the LSBs)
out_data  output  W  current stream entry
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the beat
out_last  output  1  current beat is entry N-1
out_index  output  IW  index of the current beat
busy  output  1  high while in SEND
done  output  1  one-cycle pulse after the final transfer
order_err  output  1  sticky: some streamed entry was less than its predecessor

Behaviour:
- Interface: reset is synchronous, active-high, named reset. Clock is clk.
- Reset: state=IDLE. The following are 0: out_valid, out_last, out_index, out_data, busy, done, order_err, complete_d, and the capture buffer.
- Edge detect: complete_d<=complete each cycle. start = complete & ~complete_d & (state==IDLE). Because complete_d resets to 0, a complete already high at reset release triggers a capture.
- States: IDLE, SEND, DONE.
- IDLE:
  - On start, register d_flat into the buffer, set idx=0, clear order_err, go to SEND.
  - out_valid rises in the cycle after the start edge, which is 1-cycle latency.
- SEND:
  - out_valid=1, busy=1, out_data=buf[idx], out_index=idx, out_last=(idx==N-1).
  - Transfer = out_valid & out_ready.
  - Without a transfer, out_data, out_index and out_last hold stable.
  - On a transfer with idx<N-1: idx<=idx+1, prev<=out_data.
  - On a transfer with idx==N-1: go to DONE, out_valid<=0.
  - Back-to-back transfers give one beat per cycle.
- order_err: set on any transfer with idx>0 and out_data<prev (unsigned compare). It stays set until the next capture or reset.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0.
- Retrigger: while complete stays high, no new stream starts. It must go low and then rise again.
- A rising edge of complete during SEND or DONE is ignored and is not queued.
- d_flat changes after capture have no effect on the current stream.
- Reset mid-stream: reset wins. The next cycle has out_valid=0 and state=IDLE, and partial data is discarded.
- idx never wraps; the SEND→DONE exit at N-1 prevents overflow.

Decomposition:
- Package sort_pkg holds:
  - N and W defaults, and IW=$clog2(N)
  - the state enum {IDLE, SEND, DONE}
  - the flat-array slice helper
- One natural sub-module, sort_edge_det: a registered rising-edge detector on complete. It is reusable for the sorter's other consumers.

Test Plan:
1. Reset; d_flat={1,2,3,4,5,6,7,8}; raise complete; out_ready=1. Expected:
   - out_valid from the next cycle
   - beats 1..8 on 8 consecutive cycles, out_index 0..7
   - out_last only on value 8
   - done pulses 1 cycle later, order_err=0
2. Same data, out_ready alternating 1,0,1,0… Expected:
   - 8 transfers over 16 cycles
   - out_data/out_index stable across every stalled cycle
   - done after beat 8
3. Unsorted d_flat={4,5,1,3,2,6,8,7}, ready=1. Expected:
   - streamed in the order given
   - order_err rises after beat 2 (1<5) and stays 1 through done
   - a new capture of {1..8} clears it
4. Hold complete high after done. Expected:
   - no second stream for 20 cycles
   - drop complete for 1 cycle, raise it: a second full 8-beat stream
5. Assert reset after the 3rd transfer. Expected:
   - out_valid=0 and busy=0 the next cycle
   - with complete still high after release: a new stream restarting at index 0
6. Change d_flat to all 8'hFF in the cycle after capture. Expected:
   - streamed values remain the captured {1..8}
   - a pulse on complete during SEND causes no restart

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sizes, state encoding and array slice helper for the sort stream stage
package sort_pkg;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry k of the sorter's flat array; D0 sits in the LSBs.
  function automatic logic [W-1:0] flat_entry(input logic [N*W-1:0] flat, input int k);
    return flat[k*W +: W];
  endfunction
endpackage

// File: rtl/sort_edge_det.sv
// rtl/sort_edge_det.sv - registered rising-edge detector for the sorter complete flag
module sort_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic sig_d;

  // sig_d resets low so a level already high at reset release reads as an edge.
  always_ff @(posedge clk) begin
    if (reset) sig_d <= 1'b0;
    else       sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
endmodule

// File: rtl/sort_stream_out.sv
// rtl/sort_stream_out.sv - captures the sorted array and streams it out one entry per beat
module sort_stream_out
  import sort_pkg::*;
#(
  parameter int N  = sort_pkg::N,
  parameter int W  = sort_pkg::W,
  parameter int IW = sort_pkg::IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          complete,
  input  logic [N*W-1:0] d_flat,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [IW-1:0] out_index,
  output logic          busy,
  output logic          done,
  output logic          order_err
);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state_q, state_d;
  logic          rise, start, xfer;
  logic [W-1:0]  buf_q [N];
  logic [IW-1:0] idx_q;
  logic [W-1:0]  prev_q;
  logic          err_q;

  sort_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (complete),
    .rise  (rise)
  );

  // Edges outside IDLE are dropped, not queued.
  assign start = rise & (state_q == IDLE);
  assign xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (xfer && idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    case (state_q)
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = buf_q[idx_q];
        out_index = idx_q;
        out_last  = (idx_q == LAST_IDX);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // idx stops at LAST_IDX; leaving SEND there keeps it from wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      prev_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < N; k++) buf_q[k] <= '0;
    end else if (start) begin
      idx_q  <= '0;
      prev_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < N; k++) buf_q[k] <= flat_entry(d_flat, k);
    end else if (xfer) begin
      if (idx_q != '0 && out_data < prev_q) err_q <= 1'b1;
      if (idx_q != LAST_IDX) begin
        idx_q  <= idx_q + 1'b1;
        prev_q <= out_data;
      end
    end
  end

  assign order_err = err_q;
endmodule

// File: tb/tb_sort_stream_out.sv
// tb/tb_sort_stream_out.sv - directed table-driven bench for sort_stream_out
module tb_sort_stream_out;
  logic        clk = 1'b0;
  logic        reset, complete, out_ready;
  logic [63:0] d_flat;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, done, order_err;
  logic [2:0]  out_index;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic [2:0] index;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t rows[$];
  logic [7:0] seq3 [8] = '{8'd4, 8'd5, 8'd1, 8'd3, 8'd2, 8'd6, 8'd8, 8'd7};

  sort_stream_out dut (
    .clk       (clk),
    .reset     (reset),
    .complete  (complete),
    .d_flat    (d_flat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index),
    .busy      (busy),
    .done      (done),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pack(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic [2:0] i,
                              input logic l, b, dn, e);
    vec_t x;
    x.ready = r; x.valid = v; x.data = d; x.index = i;
    x.last = l; x.busy = b; x.done = dn; x.err = e;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string nm, input vec_t v);
    out_ready = v.ready;
    chk({nm, "/valid"}, 32'(out_valid), 32'(v.valid));
    chk({nm, "/busy"},  32'(busy),      32'(v.busy));
    chk({nm, "/done"},  32'(done),      32'(v.done));
    chk({nm, "/err"},   32'(order_err), 32'(v.err));
    if (v.valid) begin
      chk({nm, "/data"},  32'(out_data),  32'(v.data));
      chk({nm, "/index"}, 32'(out_index), 32'(v.index));
      chk({nm, "/last"},  32'(out_last),  32'(v.last));
    end
    step();
  endtask

  task automatic run_rows(input string nm);
    for (int i = 0; i < rows.size(); i++) expect_cycle($sformatf("%s[%0d]", nm, i), rows[i]);
    rows.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; complete = 1'b0; out_ready = 1'b0; d_flat = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic start(input logic [63:0] data);
    d_flat = data;
    complete = 1'b1;
    step();
  endtask

  task automatic add_sorted_stream(input logic err);
    for (int k = 0; k < 8; k++) rows.push_back(mk(1, 1, 8'(k + 1), 3'(k), k == 7, 1, 0, err));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 1, err));
  endtask

  logic [63:0] ramp;

  initial begin
    ramp = pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);

    // reset state
    do_reset();
    chk("rst/valid", 32'(out_valid), 0);
    chk("rst/busy",  32'(busy), 0);
    chk("rst/done",  32'(done), 0);
    chk("rst/err",   32'(order_err), 0);
    chk("rst/data",  32'(out_data), 0);
    chk("rst/index", 32'(out_index), 0);
    chk("rst/last",  32'(out_last), 0);

    // 1: sorted stream, ready always high
    start(ramp);
    add_sorted_stream(0);
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_rows("t1");

    // 4: complete held high -> no restart; drop and raise -> new stream
    for (int c = 0; c < 20; c++) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_rows("t4_hold");
    complete = 1'b0;
    step();
    start(ramp);
    add_sorted_stream(0);
    run_rows("t4_again");

    // 2: ready alternating 0,1 -> stalled beats hold
    do_reset();
    start(ramp);
    for (int c = 0; c < 16; c++)
      rows.push_back(mk(1'(c % 2), 1, 8'(c / 2 + 1), 3'(c / 2), (c / 2) == 7, 1, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_rows("t2");

    // 3: unsorted input raises order_err after the 1<5 beat
    do_reset();
    start(pack(8'd4, 8'd5, 8'd1, 8'd3, 8'd2, 8'd6, 8'd8, 8'd7));
    for (int k = 0; k < 8; k++) rows.push_back(mk(1, 1, seq3[k], 3'(k), k == 7, 1, 0, k >= 3));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    run_rows("t3");
    complete = 1'b0;
    step();
    start(ramp);
    add_sorted_stream(0);
    run_rows("t3_clear");

    // 5: reset after the third transfer, complete kept high
    do_reset();
    start(ramp);
    for (int k = 0; k < 3; k++) rows.push_back(mk(1, 1, 8'(k + 1), 3'(k), 0, 1, 0, 0));
    run_rows("t5_pre");
    chk("t5/idx_before_reset", 32'(out_index), 3);
    reset = 1'b1;
    step();
    chk("t5/valid_after_reset", 32'(out_valid), 0);
    chk("t5/busy_after_reset",  32'(busy), 0);
    reset = 1'b0;
    step();
    add_sorted_stream(0);
    run_rows("t5_restart");

    // 6: d_flat changes after capture and a complete pulse mid-stream are ignored
    do_reset();
    start(ramp);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) d_flat = '1;
      if (k == 2) complete = 1'b0;
      if (k == 3) complete = 1'b1;
      expect_cycle($sformatf("t6[%0d]", k), mk(1, 1, 8'(k + 1), 3'(k), k == 7, 1, 0, 0));
    end
    expect_cycle("t6_done", mk(1, 0, 0, 0, 0, 0, 1, 0));
    for (int c = 0; c < 5; c++) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_rows("t6_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
